// File: rtl/instmem_fetch.sv
// Byte-addressable Y86 instruction memory with a byte-wide load port and a registered, handshaked fetch path.
// Optional predecode outputs (resp_len, resp_inv) are enabled by defining IMEM_PREDECODE_EN.
module instmem_fetch #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned FETCH_BYTES = 10,
    parameter int unsigned PC_W        = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [7:0]               load_data,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [PC_W-1:0]          req_pc,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [8*FETCH_BYTES-1:0] resp_inst,
    output logic                     resp_err
`ifdef IMEM_PREDECODE_EN
    ,
    output logic [3:0]               resp_len,
    output logic                     resp_inv
`endif
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned INST_W = 8 * FETCH_BYTES;
    localparam int unsigned EXT_W  = PC_W + 1;

    logic [7:0]        mem [DEPTH];
    logic              accept;
    logic [INST_W-1:0] fetch_inst;
    logic              fetch_err;
    logic [EXT_W-1:0]  byte_addr;

    // Program store; contents survive reset, but a load coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (load_en && rst_n) begin
            mem[load_addr] <= load_data;
        end
    end

    // A single output slot: accept whenever it is empty or draining this cycle, and never while loading.
    assign req_ready = !load_en && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    // Range check is done one bit wider than the PC so that req_pc+k never wraps.
    always_comb begin
        fetch_inst = '0;
        fetch_err  = 1'b0;
        byte_addr  = '0;
        for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
            byte_addr = {1'b0, req_pc} + EXT_W'(k);
            if (byte_addr >= EXT_W'(DEPTH)) begin
                fetch_err = 1'b1;
            end else begin
                fetch_inst[8*k +: 8] = mem[byte_addr[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_inst  <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_inst  <= fetch_inst;
            resp_err   <= fetch_err;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef IMEM_PREDECODE_EN
    // Instruction length from icode; {len, invalid}.
    function automatic logic [4:0] predecode(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:       return {4'd1, 1'b0};
            4'h2, 4'h6, 4'hA, 4'hB: return {4'd2, 1'b0};
            4'h7, 4'h8:             return {4'd9, 1'b0};
            4'h3, 4'h4, 4'h5:       return {4'd10, 1'b0};
            default:                return {4'd0, 1'b1};
        endcase
    endfunction

    logic [4:0] pd;
    assign pd = predecode(fetch_inst[7:4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_len <= 4'd0;
            resp_inv <= 1'b0;
        end else if (accept) begin
            resp_len <= pd[4:1];
            resp_inv <= pd[0] | fetch_err;
        end
    end
`endif

endmodule

// File: tb/tb_instmem_fetch.sv
// Directed testbench for instmem_fetch: vector table for single fetches plus handshake, hazard and reset sequences.
module tb_instmem_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_en = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_pc = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [79:0] resp_inst;
    logic        resp_err;
`ifdef IMEM_PREDECODE_EN
    logic [3:0]  resp_len;
    logic        resp_inv;
`endif

    int checks = 0;
    int errors = 0;

    instmem_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_err   (resp_err)
`ifdef IMEM_PREDECODE_EN
        ,
        .resp_len   (resp_len),
        .resp_inv   (resp_inv)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] inst;
        logic        err;
        logic [3:0]  len;
        logic        inv;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{64'd0,          80'h000000000000000AF330, 1'b0, 4'd10, 1'b0};
        vt[1] = '{64'd1,          80'h00000000000000000AF3, 1'b0, 4'd0,  1'b1};
        vt[2] = '{64'd2,          80'h0000000000000000000A, 1'b0, 4'd1,  1'b0};
        vt[3] = '{64'd1014,       80'hAA998877665544332211, 1'b0, 4'd1,  1'b0};
        vt[4] = '{64'd1013,       80'h99887766554433221100, 1'b0, 4'd1,  1'b0};
        vt[5] = '{64'd1015,       80'h00AA9988776655443322, 1'b1, 4'd0,  1'b1};
        vt[6] = '{64'd1023,       80'h000000000000000000AA, 1'b1, 4'd0,  1'b1};
        vt[7] = '{64'd1024,       80'h0,                    1'b1, 4'd0,  1'b1};
        vt[8] = '{64'h1_0000_0000, 80'h0,                   1'b1, 4'd0,  1'b1};
        vt[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h0,           1'b1, 4'd0,  1'b1};

        // Reset state
        #1 rst_n = 1'b0;
        #10;
        chk("rst_valid", 80'(resp_valid), 80'(1'b0));
        chk("rst_inst", resp_inst, 80'h0);
        chk("rst_err", 80'(resp_err), 80'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_req_ready", 80'(req_ready), 80'(1'b1));

        // Clear the whole array, then load the program and the top-of-memory pattern
        for (int a = 0; a < 1024; a++) load(10'(a), 8'h00);
        load(10'd0, 8'h30);
        load(10'd1, 8'hF3);
        load(10'd2, 8'h0A);
        for (int k = 0; k < 10; k++) load(10'(1014 + k), 8'(8'h11 * (k + 1)));
        @(negedge clk);
        load_en = 1'b0;

        // Table-driven single fetches, back-to-back with resp_ready high
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_pc    = vt[i].pc;
            #1 chk($sformatf("v%0d_req_ready", i), 80'(req_ready), 80'(1'b1));
            after_edge();
            chk($sformatf("v%0d_valid", i), 80'(resp_valid), 80'(1'b1));
            chk($sformatf("v%0d_inst", i), resp_inst, vt[i].inst);
            chk($sformatf("v%0d_err", i), 80'(resp_err), 80'(vt[i].err));
`ifdef IMEM_PREDECODE_EN
            chk($sformatf("v%0d_inv", i), 80'(resp_inv), 80'(vt[i].inv));
            if (!vt[i].err) chk($sformatf("v%0d_len", i), 80'(resp_len), 80'(vt[i].len));
`endif
        end

        // Back-to-back pc=0,1,2 then drain
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_pc    = 64'(i);
            after_edge();
            chk($sformatf("b2b%0d_valid", i), 80'(resp_valid), 80'(1'b1));
            chk($sformatf("b2b%0d_byte0", i), 80'(resp_inst[7:0]), 80'(i == 0 ? 8'h30 : i == 1 ? 8'hF3 : 8'h0A));
        end
        @(negedge clk);
        req_valid = 1'b0;
        after_edge();
        chk("drain_valid", 80'(resp_valid), 80'(1'b0));
        chk("drain_inst_hold", resp_inst, 80'h0A);

        // Backpressure: response for pc=0 held while pc=10 waits
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_pc     = 64'd0;
        after_edge();
        chk("bp_valid", 80'(resp_valid), 80'(1'b1));
        @(negedge clk);
        req_pc = 64'd10;
        for (int c = 0; c < 5; c++) begin
            #1 chk($sformatf("bp%0d_req_ready", c), 80'(req_ready), 80'(1'b0));
            after_edge();
            chk($sformatf("bp%0d_inst", c), resp_inst, 80'h000000000000000AF330);
            chk($sformatf("bp%0d_valid", c), 80'(resp_valid), 80'(1'b1));
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1 chk("bp_release_ready", 80'(req_ready), 80'(1'b1));
        after_edge();
        chk("bp_pc10_valid", 80'(resp_valid), 80'(1'b1));
        chk("bp_pc10_inst", resp_inst, 80'h0);
        chk("bp_pc10_err", 80'(resp_err), 80'(1'b0));
        @(negedge clk);
        req_valid = 1'b0;
        after_edge();

        // Load priority and load-then-fetch hazard
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 10'd5;
        load_data = 8'h90;
        req_valid = 1'b1;
        req_pc    = 64'd5;
        #1 chk("ld_prio_req_ready", 80'(req_ready), 80'(1'b0));
        after_edge();
        chk("ld_prio_no_accept", 80'(resp_valid), 80'(1'b0));
        @(negedge clk);
        load_en = 1'b0;
        #1 chk("hz_req_ready", 80'(req_ready), 80'(1'b1));
        after_edge();
        chk("hz_valid", 80'(resp_valid), 80'(1'b1));
        chk("hz_inst", resp_inst, 80'h90);
`ifdef IMEM_PREDECODE_EN
        chk("hz_len", 80'(resp_len), 80'(4'd1));
        chk("hz_inv", 80'(resp_inv), 80'(1'b0));
`endif

        // Reset while a response is pending
        @(negedge clk);
        resp_ready = 1'b0;
        req_pc     = 64'd0;
        after_edge();
        chk("mid_valid_pre", 80'(resp_valid), 80'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 80'(resp_valid), 80'(1'b0));
        chk("mid_rst_inst", resp_inst, 80'h0);
        chk("mid_rst_err", 80'(resp_err), 80'(1'b0));
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        rst_n      = 1'b1;
        #1 chk("post_rst_ready", 80'(req_ready), 80'(1'b1));

        // Memory survives reset
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = 64'd5;
        after_edge();
        chk("post_rst_mem", resp_inst, 80'h90);
        @(negedge clk);
        req_valid = 1'b0;
        after_edge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
